eth_rx_fcs_strip: RTL and testbench

Receive-path stage between the PHY-side byte stream and the MAC RX frame buffer. Holds each incoming byte in a 4-deep delay line so the trailing 4-byte FCS is never forwarded. Checks CRC-32 over the whole frame and flags bad or errored frames on the final payload beat. The interface is valid-only with no backpressure, because the PHY cannot stall.

---
 rtl/eth_pkg.sv | 31 +++
 rtl/shift_register_nr.sv | 31 +++
 rtl/eth_rx_fcs_strip.sv | 104 ++++++++++
 tb/tb_eth_rx_fcs_strip.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Package : eth_pkg
// Brief   : Shared Ethernet RX constants, FSM encoding and CRC-32 byte update.
// Rev     : 1.0
// ============================================================================
package eth_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;
    localparam int          FCS_BYTES       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } rx_state_t;

    // Reflected (LSB-first) CRC-32 advanced by one byte, no final inversion.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_register_nr.sv
`default_nettype none
// ============================================================================
// Module : shift_register_nr
// Brief  : Enable-gated shift register without reset; data_out is the oldest stage.
// Rev    : 1.0
// ============================================================================
module shift_register_nr #(
    parameter int DATAW = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             enable,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out
);

    logic [DATAW-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (enable) begin
            r_stage[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign data_out = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/eth_rx_fcs_strip.sv
`default_nettype none
// ============================================================================
// Module : eth_rx_fcs_strip
// Brief  : Strips the trailing FCS from an RX byte stream and flags bad frames.
// Rev    : 1.0
// ============================================================================
module eth_rx_fcs_strip #(
    parameter int FCS_BYTES = eth_pkg::FCS_BYTES,
    parameter bit CHECK_FCS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    input  logic       s_error,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    output logic       m_user,
    output logic       stat_fcs_bad,
    output logic       stat_runt
);

    import eth_pkg::*;

    localparam logic [2:0] c_fill_full = 3'(FCS_BYTES);

    rx_state_t   r_state;
    logic [2:0]  r_fill;
    logic [31:0] r_crc;
    logic        r_err;

    logic [7:0]  w_oldest;
    logic [31:0] w_crc_next;
    logic        w_crc_bad;
    logic        w_err;
    logic [2:0]  w_fill_inc;

    shift_register_nr #(
        .DATAW (8),
        .DEPTH (FCS_BYTES)
    ) u_delay (
        .clk      (clk),
        .enable   (s_valid),
        .data_in  (s_data),
        .data_out (w_oldest)
    );

    assign w_crc_next = crc32_byte(r_crc, s_data);
    assign w_crc_bad  = CHECK_FCS && (w_crc_next != CRC32_RESIDUE);
    assign w_err      = r_err | s_error;
    assign w_fill_inc = r_fill + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_fill       <= 3'd0;
            r_crc        <= CRC32_INIT;
            r_err        <= 1'b0;
            m_data       <= 8'h00;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            m_user       <= 1'b0;
            stat_fcs_bad <= 1'b0;
            stat_runt    <= 1'b0;
        end else begin
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            m_user       <= 1'b0;
            stat_fcs_bad <= 1'b0;
            stat_runt    <= 1'b0;
            if (s_valid) begin
                if (r_state == ST_RUN) begin
                    m_valid <= 1'b1;
                    m_data  <= w_oldest;
                end
                if (s_last) begin
                    // Frame closes here; the delay line keeps stale FCS bytes but fill=0 hides them.
                    r_state <= ST_IDLE;
                    r_fill  <= 3'd0;
                    r_crc   <= CRC32_INIT;
                    r_err   <= 1'b0;
                    if (r_state == ST_RUN) begin
                        m_last       <= 1'b1;
                        m_user       <= w_crc_bad | w_err;
                        stat_fcs_bad <= w_crc_bad;
                    end else begin
                        stat_runt <= 1'b1;
                    end
                end else begin
                    r_crc <= w_crc_next;
                    r_err <= w_err;
                    if (r_state != ST_RUN) begin
                        r_fill  <= w_fill_inc;
                        r_state <= (w_fill_inc == c_fill_full) ? ST_RUN : ST_FILL;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_fcs_strip.sv
`default_nettype none
// ============================================================================
// Module : tb_eth_rx_fcs_strip
// Brief  : Directed self-checking bench for eth_rx_fcs_strip.
// Rev    : 1.0
// ============================================================================
module tb_eth_rx_fcs_strip;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_error = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_user;
    logic       stat_fcs_bad;
    logic       stat_runt;

    eth_rx_fcs_strip #(
        .FCS_BYTES (4),
        .CHECK_FCS (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_error      (s_error),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_last       (m_last),
        .m_user       (m_user),
        .stat_fcs_bad (stat_fcs_bad),
        .stat_runt    (stat_runt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    bit acc_edge = 1'b0;
    always @(posedge clk) begin
        cyc      = cyc + 1;
        acc_edge = s_valid && !rst;
    end

    logic [7:0] rx_data [$];
    bit         rx_last [$];
    bit         rx_user [$];
    int n_fcs = 0, n_runt = 0, runt_cyc = 0, lat_err = 0, fcs_misalign = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            rx_data.push_back(m_data);
            rx_last.push_back(m_last);
            rx_user.push_back(m_user);
            if (!acc_edge) lat_err = lat_err + 1;
        end
        if (stat_fcs_bad) begin
            n_fcs = n_fcs + 1;
            if (!(m_valid && m_last)) fcs_misalign = fcs_misalign + 1;
        end
        if (stat_runt) begin
            n_runt   = n_runt + 1;
            runt_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] tx [$];
    int last_cyc = 0;
    int b_beat = 0, b_fcs = 0, b_runt = 0, b_lat = 0, b_mis = 0;

    function automatic logic [31:0] ref_crc(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB8_8320;
        end
        return c;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Payload bytes are 0,1,2,...; FCS is the inverted CRC sent LSB first.
    task automatic build(input int npay, input bit flip);
        logic [31:0] c;
        tx.delete();
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < npay; i++) begin
            tx.push_back(8'(i));
            c = ref_crc(c, 8'(i));
        end
        c = ~c;
        for (int k = 0; k < 4; k++) tx.push_back(c[8*k +: 8]);
        if (flip) tx[npay] = tx[npay] ^ 8'h01;
    endtask

    task automatic drive(input int gap, input int err_idx, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = tx[i];
            s_last  = (i == tx.size() - 1);
            s_error = (i == err_idx);
            if (s_last) last_cyc = cyc + 1;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                s_valid = 1'b0;
                s_data  = 8'hAA;
                s_last  = 1'b1;
                s_error = 1'b1;
            end
        end
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_error = 1'b0;
        repeat (k - 1) @(negedge clk);
        #1;
    endtask

    task automatic mark();
        b_beat = rx_data.size();
        b_fcs  = n_fcs;
        b_runt = n_runt;
        b_lat  = lat_err;
        b_mis  = fcs_misalign;
    endtask

    task automatic check_frames(input string tag, input int npay, input int nfr,
                                input int exp_user, input int exp_fcs);
        int mism, lmism, umism, nb;
        mism = 0; lmism = 0; umism = 0;
        nb = rx_data.size() - b_beat;
        chk({tag, ".beats"}, nb, npay * nfr);
        for (int j = 0; j < nb; j++) begin
            if (rx_data[b_beat+j] !== 8'(j % npay)) mism++;
            if (rx_last[b_beat+j] !== ((j % npay) == npay - 1)) lmism++;
            if (rx_last[b_beat+j] && (int'(rx_user[b_beat+j]) != exp_user)) umism++;
        end
        chk({tag, ".data"}, mism, 0);
        chk({tag, ".last"}, lmism, 0);
        chk({tag, ".user"}, umism, 0);
        chk({tag, ".fcs_bad"}, n_fcs - b_fcs, exp_fcs);
        chk({tag, ".runt"}, n_runt - b_runt, 0);
        chk({tag, ".fcs_align"}, fcs_misalign - b_mis, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nl;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.m_data", int'(m_data), 0);
        chk("rst.m_valid", int'(m_valid), 0);
        chk("rst.m_last", int'(m_last), 0);
        chk("rst.m_user", int'(m_user), 0);
        chk("rst.stat_fcs_bad", int'(stat_fcs_bad), 0);
        chk("rst.stat_runt", int'(stat_runt), 0);
        rst = 1'b0;

        build(60, 1'b0); mark();
        drive(0, -1, 64); idle(3);
        check_frames("good", 60, 1, 0, 0);

        build(60, 1'b1); mark();
        drive(0, -1, 64); idle(3);
        check_frames("badfcs", 60, 1, 1, 1);

        build(0, 1'b0); void'(tx.pop_back()); mark();
        drive(0, -1, 3); idle(3);
        chk("runt3.beats", rx_data.size() - b_beat, 0);
        chk("runt3.count", n_runt - b_runt, 1);
        chk("runt3.timing", runt_cyc, last_cyc);
        chk("runt3.fcs_bad", n_fcs - b_fcs, 0);

        build(1, 1'b0); mark();
        drive(0, -1, 5); idle(3);
        check_frames("five", 1, 1, 0, 0);

        build(60, 1'b0); mark();
        drive(1, -1, 64); idle(3);
        check_frames("gap", 60, 1, 0, 0);
        chk("gap.latency", lat_err - b_lat, 0);

        build(60, 1'b0); mark();
        drive(0, 9, 64); idle(3);
        check_frames("err", 60, 1, 1, 0);

        build(60, 1'b0); mark();
        drive(0, -1, 20);
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        nl = 0;
        for (int j = b_beat; j < rx_data.size(); j++) if (rx_last[j]) nl++;
        chk("rstmid.partial_beats", rx_data.size() - b_beat, 16);
        chk("rstmid.partial_last", nl, 0);
        chk("rstmid.stats", (n_fcs - b_fcs) + (n_runt - b_runt), 0);
        mark();
        drive(0, -1, 64); idle(3);
        check_frames("afterrst", 60, 1, 0, 0);

        mark();
        drive(0, -1, 64);
        drive(0, -1, 64);
        idle(3);
        check_frames("b2b", 60, 2, 0, 0);
        chk("all.latency", lat_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
